// File: rtl/dynamic_fifo_ctrl.sv
// Runtime-resizable FIFO controller wrapped around a single simple dual-port RAM
// with combinational read. Owns pointers, occupancy, flags and the depth-change sequencer.
module dynamic_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH:0]   cfg_depth,
   input  logic                  cfg_load,
   input  logic [ADDR_WIDTH:0]   cfg_almost_full,
   input  logic [ADDR_WIDTH:0]   cfg_almost_empty,
   input  logic                  clear_flags,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH:0]   depth,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  reconfig_busy,
   output logic                  ram_write_enable,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic                  ram_read_enable,
   output logic [ADDR_WIDTH-1:0] ram_read_address,
   input  logic [DATA_WIDTH-1:0] ram_read_data
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MAX_DEPTH = CW'(2 ** ADDR_WIDTH);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         pending;
   logic [CW-1:0]         count_next;
   logic [CW-1:0]         cfg_clamped;
   logic                  push;
   logic                  pop;

   // Pointers wrap at the active depth, not at the RAM size.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p,
                                                     input logic [CW-1:0] d);
      if ({1'b0, p} == d - CW'(1))
         return '0;
      else
         return p + 1'b1;
   endfunction

   assign empty        = (count == '0);
   assign full         = (count == depth);
   assign almost_full  = (count >= cfg_almost_full);
   assign almost_empty = (count <= cfg_almost_empty);

   assign in_ready  = !full && !reconfig_busy;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign ram_write_enable  = push;
   assign ram_write_address = wr_ptr;
   assign ram_write_data    = in_data;
   assign ram_read_enable   = 1'b1;
   assign ram_read_address  = rd_ptr;
   assign out_data          = ram_read_data;

   always_comb begin
      cfg_clamped = cfg_depth;
      if (cfg_depth == '0)
         cfg_clamped = CW'(1);
      else if (cfg_depth > MAX_DEPTH)
         cfg_clamped = MAX_DEPTH;
   end

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         reconfig_busy <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         depth         <= MAX_DEPTH;
         pending       <= '0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr, depth);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr, depth);
         count <= count_next;

         // A new error in the same cycle as clear_flags keeps the flag set.
         overflow  <= (in_valid && full) || (overflow && !clear_flags);
         underflow <= (out_ready && empty) || (underflow && !clear_flags);

         case (state)
            RUN: begin
               if (cfg_load) begin
                  if (empty && !push) begin
                     depth  <= cfg_clamped;
                     wr_ptr <= '0;
                     rd_ptr <= '0;
                  end else begin
                     pending       <= cfg_clamped;
                     state         <= DRAIN;
                     reconfig_busy <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Apply as soon as the last word leaves; a same-cycle request still wins.
               if (count_next == '0) begin
                  depth         <= cfg_load ? cfg_clamped : pending;
                  wr_ptr        <= '0;
                  rd_ptr        <= '0;
                  state         <= RUN;
                  reconfig_busy <= 1'b0;
               end else if (cfg_load) begin
                  pending <= cfg_clamped;
               end
            end
            default: begin
               state         <= RUN;
               reconfig_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dynamic_fifo_ctrl.sv
// Scoreboard bench: accepted writes queue their expected head words, a negedge
// monitor compares every popped word; status flags are checked at directed points.
module tb_dynamic_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW:0]   cfg_depth, cfg_almost_full, cfg_almost_empty, count, depth;
   logic          cfg_load, clear_flags, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data, ram_write_data, ram_read_data;
   logic          full, empty, almost_full, almost_empty, overflow, underflow, reconfig_busy;
   logic          ram_write_enable, ram_read_enable;
   logic [AW-1:0] ram_write_address, ram_read_address;
   logic [DW-1:0] mem [2**AW];

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   // Combinational-read RAM matching simple_dual_one_clock behaviour.
   always @(posedge clk) if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
   assign ram_read_data = mem[ram_read_address];

   dynamic_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .cfg_load(cfg_load),
      .cfg_almost_full(cfg_almost_full), .cfg_almost_empty(cfg_almost_empty),
      .clear_flags(clear_flags), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .count(count), .depth(depth), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .reconfig_busy(reconfig_busy),
      .ram_write_enable(ram_write_enable), .ram_write_address(ram_write_address),
      .ram_write_data(ram_write_data), .ram_read_enable(ram_read_enable),
      .ram_read_address(ram_read_address), .ram_read_data(ram_read_data)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every word the consumer takes must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no word", out_data);
         end else begin
            chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input bit acc);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      chk("in_ready", int'(in_ready), int'(acc));
      if (acc) exp_q.push_back(d);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_n(input int n);
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic cfg(input logic [AW:0] d);
      cfg_depth = d;
      cfg_load  = 1'b1;
      step();
      cfg_load  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cfg_depth = '0; cfg_load = 1'b0; cfg_almost_full = 5'd12;
      cfg_almost_empty = 5'd2; clear_flags = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_data = '0;
      step(); step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_depth", depth, 16);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", reconfig_busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);

      // Fill depth 16, overflow attempt, drain in order
      for (int i = 0; i < 16; i++) push(8'h10 + DW'(i), 1'b1);
      chk("t1_full", full, 1);
      chk("t1_count", count, 16);
      chk("t1_in_ready", in_ready, 0);
      push(8'hEE, 1'b0);
      chk("t1_overflow", overflow, 1);
      pop_n(16);
      chk("t1_empty", empty, 1);

      // Depth clamp boundaries
      cfg(5'd0);
      chk("clamp_zero", depth, 1);
      cfg(5'd31);
      chk("clamp_max", depth, 16);

      // Depth 5: only 5 of 7 accepted, pointer wraps on drain
      cfg(5'd5);
      chk("t2_depth", depth, 5);
      for (int i = 0; i < 7; i++) push(8'h40 + DW'(i), i < 5);
      chk("t2_full", full, 1);
      chk("t2_count", count, 5);
      pop_n(5);
      chk("t2_empty", empty, 1);
      chk("t2_rd_wrap", ram_read_address, 0);

      // Streaming push+pop at depth 5 keeps count constant
      push(8'h80, 1'b1);
      push(8'h81, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h90 + DW'(i);
         @(negedge clk);
         chk("t3_in_ready", in_ready, 1);
         chk("t3_count", count, 2);
         exp_q.push_back(in_data);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      pop_n(2);
      chk("t3_empty", empty, 1);

      // Reconfigure while holding 3 words: drain then apply
      for (int i = 0; i < 3; i++) push(8'hA0 + DW'(i), 1'b1);
      cfg(5'd8);
      chk("t4_busy", reconfig_busy, 1);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_depth_old", depth, 5);
      chk("t4_out_valid", out_valid, 1);
      pop_n(3);
      chk("t4_depth_new", depth, 8);
      chk("t4_busy_done", reconfig_busy, 0);
      chk("t4_in_ready_new", in_ready, 1);
      chk("t4_wr_ptr", ram_write_address, 0);
      chk("t4_rd_ptr", ram_read_address, 0);

      // Thresholds at depth 16
      cfg(5'd16);
      for (int k = 1; k <= 12; k++) begin
         push(8'hC0 + DW'(k), 1'b1);
         chk("t5_almost_full", almost_full, int'(k >= 12));
         chk("t5_almost_empty", almost_empty, int'(k <= 2));
      end
      pop_n(12);

      // Sticky underflow and clear priority
      clear_flags = 1'b1; step(); clear_flags = 1'b0;
      chk("t6_cleared_ovf", overflow, 0);
      chk("t6_cleared_udf", underflow, 0);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t6_underflow", underflow, 1);
      out_ready = 1'b1; clear_flags = 1'b1; step();
      out_ready = 1'b0; clear_flags = 1'b0;
      chk("t6_set_wins", underflow, 1);
      clear_flags = 1'b1; step(); clear_flags = 1'b0;
      chk("t6_clear", underflow, 0);

      // Reset mid-operation at a non-default depth
      cfg(5'd10);
      for (int i = 0; i < 6; i++) push(8'hD0 + DW'(i), 1'b1);
      chk("t7_count6", count, 6);
      rst = 1'b1; step(); rst = 1'b0;
      exp_q.delete();
      chk("t7_count", count, 0);
      chk("t7_empty", empty, 1);
      chk("t7_depth", depth, 16);
      chk("t7_overflow", overflow, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dynamic_fifo_ctrl.md
Name:
dynamic_fifo_ctrl

Overview:
- Pointer/flag controller that turns one `simple_dual_one_clock` RAM instance into a ready/valid FIFO.
- The FIFO depth can be changed at runtime, from 1 up to 2**ADDR_WIDTH entries.
- It owns the write/read pointers, occupancy count, threshold flags, sticky error flags and a depth-reconfiguration sequencer.
- It sits between the producer/consumer streams and the RAM ports. The RAM read is combinational, so the head entry is presented show-ahead.

Parameters:
- DATA_WIDTH, 8, width of the stored word; must match the RAM instance.
- ADDR_WIDTH, 4, RAM address width; the maximum depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_depth  in  ADDR_WIDTH+1  requested depth; sampled when cfg_load is high.
- cfg_load  in  1  one-cycle request to apply cfg_depth.
- cfg_almost_full  in  ADDR_WIDTH+1  almost_full threshold.
- cfg_almost_empty  in  ADDR_WIDTH+1  almost_empty threshold.
- clear_flags  in  1  clears the sticky overflow/underflow flags.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  head word is valid.
- out_ready  in  1  consumer takes the head word.
- out_data  out  DATA_WIDTH  head word (equal to ram_read_data).
- count  out  ADDR_WIDTH+1  current occupancy.
- depth  out  ADDR_WIDTH+1  currently active depth.
- full, empty, almost_full, almost_empty  out  1  status flags.
- overflow, underflow  out  1  sticky error flags.
- reconfig_busy  out  1  high while in state DRAIN.
- ram_write_enable  out  1  to RAM write_enable.
- ram_write_address  out  ADDR_WIDTH  to RAM write_address.
- ram_write_data  out  DATA_WIDTH  to RAM write_data.
- ram_read_enable  out  1  to RAM read_enable.
- ram_read_address  out  ADDR_WIDTH  to RAM read_address.
- ram_read_data  in  DATA_WIDTH  from RAM read_data (combinational).

Behaviour:
- Reset (rst=1 at a clk edge; rst is sampled only on clk edges):
  - wr_ptr=0, rd_ptr=0, count=0, depth=2**ADDR_WIDTH, pending depth cleared, state=RUN.
  - Outputs: overflow=0, underflow=0, empty=1, full=0, in_ready=1, out_valid=0, reconfig_busy=0.
  - Reset mid-operation discards all contents; no flag survives.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !full & (state==RUN).
  - out_valid = !empty, in both RUN and DRAIN.
- RAM drive:
  - ram_write_enable = push; ram_write_address = wr_ptr; ram_write_data = in_data.
  - ram_read_enable = 1; ram_read_address = rd_ptr; out_data = ram_read_data.
  - There is no fall-through: a word written while empty is visible the next cycle.
- Latency:
  - Push to out_valid: 1 cycle.
  - Pop to next head word: 0 cycles, since it is combinational from the new rd_ptr after the edge.
- Pointers:
  - Each pointer advances on its event, modulo the active depth: if ptr==depth-1 the next value is 0, else ptr+1.
  - Pointers wrap at depth, not at 2**ADDR_WIDTH.
- Count:
  - push only: +1; pop only: -1; push and pop in the same cycle: unchanged, both pointers advance.
  - Simultaneous push/pop is impossible when full (in_ready=0), and pop is impossible when empty.
- Flags (all combinational from registered state):
  - empty = (count==0); full = (count==depth).
  - almost_full = (count >= cfg_almost_full); almost_empty = (count <= cfg_almost_empty).
- Sticky errors:
  - overflow sets on in_valid & full.
  - underflow sets on out_ready & empty.
  - Both hold until clear_flags. If set and clear happen in the same cycle, set wins.
- Depth clamp: cfg_depth=0 is treated as 1; a value > 2**ADDR_WIDTH is treated as 2**ADDR_WIDTH.
- State machine, states RUN and DRAIN:
  - RUN, cfg_load & empty & !push: depth <= clamp(cfg_depth), wr_ptr=rd_ptr=0; stay in RUN.
  - RUN, cfg_load otherwise: latch pending = clamp(cfg_depth); go to DRAIN.
  - DRAIN: in_ready=0; pops continue. When count reaches 0 (including the cycle where the last pop empties it), the next state is RUN with depth=pending and both pointers = 0.
  - DRAIN, another cfg_load: overwrites pending (last request wins).
- Note: cfg_load while full in RUN goes to DRAIN; an in_valid that arrives then still sets overflow.

Test Plan:
- Reset, then push 0x10..0x1F (16 words, depth 16) -> full=1 after the 16th push, in_ready=0. An extra in_valid sets overflow=1. Pops return 0x10..0x1F in order, then empty=1.
- cfg_depth=5 with cfg_load while empty, then push 7 words -> first 5 accepted, full=1, count=5. Pop all -> order preserved, rd_ptr wraps 4->0.
- depth=5, continuous push+pop with in_valid=out_ready=1 for 20 cycles -> count stays constant, data in order, pointers wrap at 4.
- Hold 3 words, cfg_load cfg_depth=8 -> reconfig_busy=1, in_ready=0. Three pops drain -> next cycle depth=8, in_ready=1, pointers 0.
- Thresholds almost_full=12, almost_empty=2: push 12 words -> almost_full rises at count=12; almost_empty falls at count=3.
- out_ready=1 while empty -> underflow=1. clear_flags together with out_ready & empty -> underflow stays 1. clear_flags alone -> 0. Assert rst while count=6 -> count=0, empty=1, depth=16.
